// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: shared 2-bit counter encodings, BTB allocation states and index-width helper
package branch_predict_unit_pkg;
    typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} ctr_e;
    localparam logic [1:0] ALLOC_BR   = WT;
    localparam logic [1:0] ALLOC_JALR = ST;
    function automatic int idx_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/branch_predict_unit_btb_table.sv
// branch_predict_unit_btb_table: direct-mapped BTB storage; clk/reset, fetch read (i_rd_pc -> o_rd_*), execute read (i_ex_pc -> o_ex_*), one write port at i_ex_pc's index
module branch_predict_unit_btb_table
    import branch_predict_unit_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = idx_w(ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] i_rd_pc,
    output logic            o_rd_hit,
    output logic            o_rd_taken,
    output logic [PC_W-1:0] o_rd_target,
    input  logic [PC_W-1:0] i_ex_pc,
    output logic            o_ex_hit,
    output logic [PC_W-1:0] o_ex_target,
    output logic [1:0]      o_ex_ctr,
    input  logic            i_we,
    input  logic            i_wr_valid,
    input  logic [PC_W-1:0] i_wr_target,
    input  logic [1:0]      i_wr_ctr
);
    localparam int TAG_W = PC_W - IDX_W;
    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [PC_W-1:0]   r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [IDX_W-1:0]  w_ri, w_ei;
    logic [1:0]        w_rd_ctr;
    assign w_ri        = i_rd_pc[IDX_W-1:0];
    assign w_ei        = i_ex_pc[IDX_W-1:0];
    assign o_rd_hit    = r_valid[w_ri] && (r_tag[w_ri] == i_rd_pc[PC_W-1:IDX_W]);
    assign w_rd_ctr    = r_ctr[w_ri];
    assign o_rd_taken  = o_rd_hit && w_rd_ctr[1];
    assign o_rd_target = r_target[w_ri];
    assign o_ex_hit    = r_valid[w_ei] && (r_tag[w_ei] == i_ex_pc[PC_W-1:IDX_W]);
    assign o_ex_target = r_target[w_ei];
    assign o_ex_ctr    = r_ctr[w_ei];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= WNT;
            end
        end else if (i_we) begin
            r_valid[w_ei]  <= i_wr_valid;
            r_tag[w_ei]    <= i_ex_pc[PC_W-1:IDX_W];
            r_target[w_ei] <= i_wr_target;
            r_ctr[w_ei]    <= i_wr_ctr;
        end
    end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BTB-based predictor with execute-stage resolve, mispredict redirect and saturating statistics; fetch port if_*, execute port ex_*, counters stat_*
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic [PC_W-1:0]  if_pred_target,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic             ex_branch,
    input  logic             ex_jalr,
    input  logic [31:0]      ex_alu_result,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_pred_target,
    output logic             ex_taken,
    output logic [PC_W-1:0]  ex_pc_plus1,
    output logic             ex_mispredict,
    output logic [PC_W-1:0]  ex_redirect_pc,
    output logic [CNT_W-1:0] stat_ctrl,
    output logic [CNT_W-1:0] stat_mispred
);
    logic             w_rd_hit, w_rd_taken, w_ex_hit, w_ctrl, w_we;
    logic [PC_W-1:0]  w_rd_target, w_ex_target, w_act_target, w_wr_target;
    logic [1:0]       w_ex_ctr, w_wr_ctr;
    logic [CNT_W-1:0] r_ctrl, r_misp;
    logic             w_unused;
    assign w_unused = ^{ex_imm[31:PC_W], ex_alu_result[31:PC_W]};
    branch_predict_unit_btb_table #(.PC_W(PC_W), .ENTRIES(BTB_ENTRIES)) u_btb (
        .clk         (clk),
        .reset       (reset),
        .i_rd_pc     (if_pc),
        .o_rd_hit    (w_rd_hit),
        .o_rd_taken  (w_rd_taken),
        .o_rd_target (w_rd_target),
        .i_ex_pc     (ex_pc),
        .o_ex_hit    (w_ex_hit),
        .o_ex_target (w_ex_target),
        .o_ex_ctr    (w_ex_ctr),
        .i_we        (w_we),
        .i_wr_valid  (w_ctrl),
        .i_wr_target (w_wr_target),
        .i_wr_ctr    (w_wr_ctr)
    );
    assign if_pred_taken  = w_rd_taken;
    assign if_pred_target = w_rd_hit ? w_rd_target : '0;
    assign w_ctrl         = ex_branch | ex_jalr;
    assign w_act_target   = ex_jalr ? ex_alu_result[PC_W-1:0] : ex_pc + ex_imm[PC_W-1:0];
    assign ex_taken       = ex_valid & (ex_jalr | (ex_branch & ex_alu_result[0]));
    assign ex_pc_plus1    = ex_pc + PC_W'(1);
    assign ex_mispredict  = ex_valid & ((ex_pred_taken != ex_taken) | (ex_taken & (ex_pred_target != w_act_target)));
    assign ex_redirect_pc = ex_taken ? w_act_target : ex_pc_plus1;
    // a hit always writes: control trains the entry, non-control (alias) drops it via valid=w_ctrl
    assign w_we        = ex_valid & (w_ex_hit | (w_ctrl & ex_taken));
    assign w_wr_target = ex_taken ? w_act_target : w_ex_target;
    assign w_wr_ctr    = !w_ctrl ? w_ex_ctr :
                         !w_ex_hit ? (ex_jalr ? ALLOC_JALR : ALLOC_BR) :
                         ex_taken ? ((w_ex_ctr == ST) ? w_ex_ctr : w_ex_ctr + 2'd1) :
                                    ((w_ex_ctr == SNT) ? w_ex_ctr : w_ex_ctr - 2'd1);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= '0;
            r_misp <= '0;
        end else begin
            if (ex_valid && w_ctrl && !(&r_ctrl)) r_ctrl <= r_ctrl + CNT_W'(1);
            if (ex_mispredict && !(&r_misp)) r_misp <= r_misp + CNT_W'(1);
        end
    end
    assign stat_ctrl    = r_ctrl;
    assign stat_mispred = r_misp;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vectors with a queued scoreboard checked on the falling edge
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  if_pc;
    logic        if_pred_taken;
    logic [7:0]  if_pred_target;
    logic        ex_valid;
    logic [7:0]  ex_pc;
    logic [31:0] ex_imm;
    logic        ex_branch;
    logic        ex_jalr;
    logic [31:0] ex_alu_result;
    logic        ex_pred_taken;
    logic [7:0]  ex_pred_target;
    logic        ex_taken;
    logic [7:0]  ex_pc_plus1;
    logic        ex_mispredict;
    logic [7:0]  ex_redirect_pc;
    logic [3:0]  stat_ctrl;
    logic [3:0]  stat_mispred;

    typedef struct {
        string       nm;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] sc, sm;

    branch_predict_unit #(.PC_W(8), .BTB_ENTRIES(16), .CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_branch      (ex_branch),
        .ex_jalr        (ex_jalr),
        .ex_alu_result  (ex_alu_result),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_taken       (ex_taken),
        .ex_pc_plus1    (ex_pc_plus1),
        .ex_mispredict  (ex_mispredict),
        .ex_redirect_pc (ex_redirect_pc),
        .stat_ctrl      (stat_ctrl),
        .stat_mispred   (stat_mispred)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            0:       return {31'd0, if_pred_taken};
            1:       return {24'd0, if_pred_target};
            2:       return {31'd0, ex_taken};
            3:       return {24'd0, ex_pc_plus1};
            4:       return {31'd0, ex_mispredict};
            5:       return {24'd0, ex_redirect_pc};
            6:       return {28'd0, stat_ctrl};
            default: return {28'd0, stat_mispred};
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = probe(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s @%0t: got %0h expected %0h", e.nm, $time, act, e.exp);
            end
        end
    end

    task automatic push(input string nm, input int sel, input logic [31:0] v);
        exp_t e;
        e.nm = nm;
        e.sel = sel;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic drive(input bit v, input logic [7:0] pc, input logic [31:0] imm, input bit br,
                         input bit jr, input logic [31:0] alu, input bit pt, input logic [7:0] ptgt,
                         input logic [7:0] ifpc);
        ex_valid = v; ex_pc = pc; ex_imm = imm; ex_branch = br; ex_jalr = jr;
        ex_alu_result = alu; ex_pred_taken = pt; ex_pred_target = ptgt; if_pc = ifpc;
    endtask

    task automatic cyc(input string nm, input bit v, input logic [7:0] pc, input logic [31:0] imm,
                       input bit br, input bit jr, input logic [31:0] alu, input bit pt,
                       input logic [7:0] ptgt, input logic [7:0] ifpc, input bit e_pt,
                       input logic [7:0] e_ptgt, input bit e_tk, input bit e_mp, input logic [7:0] e_rd);
        logic [7:0] p1;
        p1 = pc + 8'd1;
        drive(v, pc, imm, br, jr, alu, pt, ptgt, ifpc);
        push({nm, ".if_pred_taken"}, 0, {31'd0, e_pt});
        push({nm, ".if_pred_target"}, 1, {24'd0, e_ptgt});
        push({nm, ".ex_taken"}, 2, {31'd0, e_tk});
        push({nm, ".ex_pc_plus1"}, 3, {24'd0, p1});
        push({nm, ".ex_mispredict"}, 4, {31'd0, e_mp});
        push({nm, ".ex_redirect_pc"}, 5, {24'd0, e_rd});
        push({nm, ".stat_ctrl"}, 6, {28'd0, sc});
        push({nm, ".stat_mispred"}, 7, {28'd0, sm});
        if (v && (br || jr) && sc != 4'hF) sc = sc + 4'd1;
        if (e_mp && sm != 4'hF) sm = sm + 4'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        sc = 4'd0;
        sm = 4'd0;
        reset = 1'b1;
        drive(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("rst",      0, 8'h20, 0,    0, 0, 0,       0, 8'h00, 8'h10, 0, 8'h00, 0, 0, 8'h21);
        cyc("br_alloc", 1, 8'h10, 8,    1, 0, 1,       0, 8'h00, 8'h10, 0, 8'h00, 1, 1, 8'h18);
        cyc("br_nt1",   1, 8'h10, 8,    1, 0, 0,       1, 8'h18, 8'h10, 1, 8'h18, 0, 1, 8'h11);
        cyc("br_nt2",   1, 8'h10, 8,    1, 0, 0,       0, 8'h18, 8'h10, 0, 8'h18, 0, 0, 8'h11);
        cyc("br_t1",    1, 8'h10, 8,    1, 0, 1,       0, 8'h18, 8'h10, 0, 8'h18, 1, 1, 8'h18);
        cyc("br_t2",    1, 8'h10, 8,    1, 0, 1,       0, 8'h18, 8'h10, 0, 8'h18, 1, 1, 8'h18);
        cyc("br_t3",    1, 8'h10, 8,    1, 0, 1,       1, 8'h18, 8'h10, 1, 8'h18, 1, 0, 8'h18);
        cyc("br_t4",    1, 8'h10, 8,    1, 0, 1,       1, 8'h18, 8'h10, 1, 8'h18, 1, 0, 8'h18);
        cyc("br_sat",   1, 8'h10, 8,    1, 0, 1,       1, 8'h18, 8'h10, 1, 8'h18, 1, 0, 8'h18);
        cyc("br_dn1",   1, 8'h10, 8,    1, 0, 0,       1, 8'h18, 8'h10, 1, 8'h18, 0, 1, 8'h11);
        cyc("br_dn2",   1, 8'h10, 8,    1, 0, 0,       1, 8'h18, 8'h10, 1, 8'h18, 0, 1, 8'h11);
        cyc("br_look",  0, 8'h00, 0,    0, 0, 0,       0, 8'h00, 8'h10, 0, 8'h18, 0, 0, 8'h01);
        cyc("jalr_al",  1, 8'h25, 0,    0, 1, 32'h140, 0, 8'h00, 8'h25, 0, 8'h00, 1, 1, 8'h40);
        cyc("jalr_chg", 1, 8'h25, 0,    0, 1, 32'h1F3, 1, 8'h40, 8'h25, 1, 8'h40, 1, 1, 8'hF3);
        cyc("jalr_ok",  1, 8'h25, 0,    0, 1, 32'h1F3, 1, 8'hF3, 8'h25, 1, 8'hF3, 1, 0, 8'hF3);
        cyc("jalr_pri", 1, 8'h25, 8,    1, 1, 32'h1F2, 1, 8'hF3, 8'h25, 1, 8'hF3, 1, 1, 8'hF2);
        cyc("alias",    1, 8'h10, 0,    0, 0, 0,       1, 8'h18, 8'h10, 0, 8'h18, 0, 1, 8'h11);
        cyc("alias_inv",0, 8'hFF, 0,    0, 0, 0,       0, 8'h00, 8'h10, 0, 8'h00, 0, 0, 8'h00);
        cyc("wrap_tgt", 1, 8'hFF, 2,    1, 0, 1,       0, 8'h00, 8'hFF, 0, 8'h00, 1, 1, 8'h01);
        cyc("idx3_al",  1, 8'h03, 8'h10,1, 0, 1,       0, 8'h00, 8'h03, 0, 8'h00, 1, 1, 8'h13);
        cyc("idx3_same",1, 8'h03, 8'h20,1, 0, 1,       1, 8'h13, 8'h03, 1, 8'h13, 1, 1, 8'h23);
        cyc("idx3_new", 0, 8'h00, 0,    0, 0, 0,       0, 8'h00, 8'h03, 1, 8'h23, 0, 0, 8'h01);
        cyc("idx15",    0, 8'h00, 0,    0, 0, 0,       0, 8'h00, 8'hFF, 1, 8'h01, 0, 0, 8'h01);
        reset = 1'b1;
        drive(1, 8'h07, 4, 1, 0, 1, 0, 8'h00, 8'h07);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sc = 4'd0;
        sm = 4'd0;
        cyc("rst_upd",  0, 8'h00, 0,    0, 0, 0,       0, 8'h00, 8'h07, 0, 8'h00, 0, 0, 8'h01);
        cyc("rst_clr",  0, 8'h00, 0,    0, 0, 0,       0, 8'h00, 8'h03, 0, 8'h00, 0, 0, 8'h01);
        for (int i = 0; i < 18; i++)
            cyc("sat_run", 1, 8'h30, 4, 1, 0, 1, 0, 8'h00, 8'h30, i > 0, (i > 0) ? 8'h34 : 8'h00, 1, 1, 8'h34);
        cyc("sat_end",  0, 8'h00, 0,    0, 0, 0,       0, 8'h00, 8'h30, 1, 8'h34, 0, 0, 8'h01);
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
